// File: rtl/bi_channel_ctrl_pkg.sv
// Shared types and constants for the bidirectional channel direction controller.
// The FSM encoding lives here so both channel ends agree on it.
package bi_channel_ctrl_pkg;

  localparam int DW_DEF = 32;

  typedef enum logic [2:0] {
    CS_FREE     = 3'd0,
    CS_OWN_IDLE = 3'd1,
    CS_OWN_TX   = 3'd2,
    CS_DRAIN    = 3'd3,
    CS_TURN     = 3'd4
  } chan_state_e;

  localparam logic [2:0] ST_FREE     = CS_FREE;
  localparam logic [2:0] ST_OWN_IDLE = CS_OWN_IDLE;
  localparam logic [2:0] ST_OWN_TX   = CS_OWN_TX;
  localparam logic [2:0] ST_DRAIN    = CS_DRAIN;
  localparam logic [2:0] ST_TURN     = CS_TURN;

  // Every state except FREE means this end holds the token.
  function automatic logic holds_token(input logic [2:0] st);
    return st != ST_FREE;
  endfunction

endpackage

// File: rtl/bi_channel_ctrl_if.sv
// Local send stream from the router output buffer into one channel end.
import bi_channel_ctrl_pkg::*;

interface bi_channel_ctrl_if #(
  parameter int DW = DW_DEF
);
  logic          send_valid;
  logic [DW-1:0] send_data;
  logic          send_ready;

  modport master (output send_valid, output send_data, input send_ready);
  modport slave  (input send_valid, input send_data, output send_ready);
endinterface

// File: rtl/bi_channel_ctrl.sv
// Direction controller for one end of a bidirectional inter-router channel:
// token negotiation with the peer, bounded bursts, and a tristate turnaround.
module bi_channel_ctrl
  import bi_channel_ctrl_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int MAX_HOLD  = 8,
  parameter int TURN_CYC  = 1,
  parameter bit HIGH_PRIO = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  bi_channel_ctrl_if.slave send,
  input  logic            peer_req_in,
  input  logic            grant_in,
  output logic            req_out,
  output logic            grant_out,
  output logic            inout_select,
  output logic [DW-1:0]   link_data,
  output logic            link_valid,
  output logic            own,
  output logic            proto_err
);

  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam int TCW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [2:0]     RST_STATE = HIGH_PRIO ? ST_OWN_IDLE : ST_FREE;
  localparam logic [HCW-1:0] HOLD_MAX  = HCW'(MAX_HOLD);
  localparam logic [TCW-1:0] TURN_LAST = TCW'(TURN_CYC - 1);

  logic [2:0]     state_q, state_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TCW-1:0] turn_cnt_q, turn_cnt_d;
  logic           req_q, req_d;
  logic           grant_q, grant_d;
  logic           sel_q, sel_d;
  logic           lv_q, lv_d;
  logic           own_q, own_d;
  logic           perr_q, perr_d;
  logic [DW-1:0]  ld_q, ld_d;

  logic hold_hit;
  logic tx_exit;
  logic fire;

  always_comb begin
    hold_hit        = peer_req_in && (hold_cnt_q == HOLD_MAX);
    tx_exit         = (state_q == ST_OWN_TX) && (!send.send_valid || hold_hit);
    send.send_ready = (state_q == ST_OWN_TX) && !tx_exit;
    fire            = send.send_valid && send.send_ready;

    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    grant_d    = 1'b0;

    case (state_q)
      ST_FREE: begin
        if (grant_in) state_d = ST_OWN_IDLE;
      end
      ST_OWN_IDLE: begin
        // Local demand wins over a waiting peer.
        if (send.send_valid) begin
          state_d    = ST_OWN_TX;
          hold_cnt_d = '0;
        end else if (peer_req_in) begin
          state_d    = ST_TURN;
          turn_cnt_d = '0;
        end
      end
      ST_OWN_TX: begin
        if (tx_exit) begin
          state_d = ST_DRAIN;
        end else if (fire && peer_req_in) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (peer_req_in) begin
          state_d    = ST_TURN;
          turn_cnt_d = '0;
        end else begin
          state_d = ST_OWN_IDLE;
        end
      end
      ST_TURN: begin
        if (turn_cnt_q == TURN_LAST) begin
          state_d = ST_FREE;
          grant_d = 1'b1;
        end else begin
          turn_cnt_d = turn_cnt_q + 1'b1;
        end
      end
      default: state_d = RST_STATE;
    endcase

    // Request is sticky while free so a brief send_valid gap cannot drop it.
    req_d  = (state_q == ST_FREE && !grant_in) ? (req_q | send.send_valid) : 1'b0;
    perr_d = perr_q | (grant_in && holds_token(state_q));
    lv_d   = fire;
    ld_d   = fire ? send.send_data : ld_q;
    sel_d  = fire || (state_d == ST_OWN_TX) || (state_d == ST_DRAIN);
    own_d  = holds_token(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST_STATE;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      req_q      <= 1'b0;
      grant_q    <= 1'b0;
      sel_q      <= 1'b0;
      lv_q       <= 1'b0;
      own_q      <= 1'b0;
      perr_q     <= 1'b0;
      ld_q       <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      req_q      <= req_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      lv_q       <= lv_d;
      own_q      <= own_d;
      perr_q     <= perr_d;
      ld_q       <= ld_d;
    end
  end

  assign req_out      = req_q;
  assign grant_out    = grant_q;
  assign inout_select = sel_q;
  assign link_data    = ld_q;
  assign link_valid   = lv_q;
  assign own          = own_q;
  assign proto_err    = perr_q;

endmodule

// File: tb/tb_bi_channel_ctrl.sv
// Two cross-connected channel ends (A high priority) with a transaction-level
// scoreboard and channel-level invariants checked every cycle.
module tb_bi_channel_ctrl;

  localparam int DW       = 32;
  localparam int MAX_HOLD = 8;
  localparam int TURN_CYC = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bi_channel_ctrl_if #(.DW(DW)) sif_a ();
  bi_channel_ctrl_if #(.DW(DW)) sif_b ();

  logic [1:0]    sv, sr, req, grant, sel, lv, own, perr;
  logic [DW-1:0] sd [2];
  logic [DW-1:0] ld [2];
  logic          inj_b;

  assign sif_a.send_valid = sv[0];
  assign sif_a.send_data  = sd[0];
  assign sif_b.send_valid = sv[1];
  assign sif_b.send_data  = sd[1];
  assign sr[0] = sif_a.send_ready;
  assign sr[1] = sif_b.send_ready;

  bi_channel_ctrl #(.DW(DW), .MAX_HOLD(MAX_HOLD), .TURN_CYC(TURN_CYC), .HIGH_PRIO(1'b1)) u_a (
    .clk(clk), .rst(rst), .send(sif_a.slave),
    .peer_req_in(req[1]), .grant_in(grant[1]),
    .req_out(req[0]), .grant_out(grant[0]), .inout_select(sel[0]),
    .link_data(ld[0]), .link_valid(lv[0]), .own(own[0]), .proto_err(perr[0])
  );

  bi_channel_ctrl #(.DW(DW), .MAX_HOLD(MAX_HOLD), .TURN_CYC(TURN_CYC), .HIGH_PRIO(1'b0)) u_b (
    .clk(clk), .rst(rst), .send(sif_b.slave),
    .peer_req_in(req[0]), .grant_in(grant[0] | inj_b),
    .req_out(req[1]), .grant_out(grant[1]), .inout_select(sel[1]),
    .link_data(ld[1]), .link_valid(lv[1]), .own(own[1]), .proto_err(perr[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Source model: each end offers base+index flits up to quota, gated by pct.
  int            sent  [2] = '{0, 0};
  int            quota [2] = '{0, 0};
  int            pct   [2] = '{100, 100};
  logic [DW-1:0] base  [2] = '{32'h0, 32'h0};

  initial begin
    sv = 2'b00;
    sd[0] = '0;
    sd[1] = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        sv[i] = (sent[i] < quota[i]) && ($urandom_range(99) < pct[i]);
        sd[i] = base[i] + DW'(sent[i]);
      end
    end
  end

  // Scoreboard and invariant monitor.
  logic [DW-1:0] exp_q [2][$];
  logic [DW-1:0] rx_log [$];
  int            rx_cnt  [2] = '{0, 0};
  int            ten_cnt [2] = '{0, 0};
  int            ten_idx [2] = '{0, 0};
  int            gcnt = 0;
  bit            sat_mode = 1'b0;
  bit            sel_a_seen = 1'b0;
  logic [1:0]    grant_prev = 2'b00;
  int            mj;
  logic [DW-1:0] me;

  always @(negedge clk) begin
    if (rst) begin
      exp_q[0].delete();
      exp_q[1].delete();
      ten_cnt[0] = 0;
      ten_cnt[1] = 0;
      grant_prev = 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        mj = 1 - i;
        chk($sformatf("link_valid[%0d]", i), lv[i], exp_q[i].size() != 0);
        if (exp_q[i].size() != 0) begin
          me = exp_q[i].pop_front();
          if (lv[i]) chk($sformatf("link_data[%0d]", i), ld[i], me);
        end
        if (lv[i]) begin
          chk($sformatf("sel_on_valid[%0d]", i), sel[i], 1'b1);
          rx_cnt[i]++;
          if (i == 0) rx_log.push_back(ld[i]);
        end
        if (sel[i]) begin
          chk($sformatf("sel_needs_own[%0d]", i), own[i], 1'b1);
          if (i == 0) sel_a_seen = 1'b1;
        end
        if (sr[i]) chk($sformatf("ready_needs_own[%0d]", i), own[i], 1'b1);
        if (grant_prev[i]) chk($sformatf("grant_to_peer_own[%0d]", i), own[mj], 1'b1);
        if (grant[i]) begin
          gcnt++;
          chk($sformatf("grant_own_sel_off[%0d]", i), {own[i], sel[i]}, 2'b00);
          if (sat_mode && ten_idx[i] > 0)
            chk($sformatf("tenure_len[%0d]", i), ten_cnt[i], MAX_HOLD);
          if (sat_mode) ten_idx[i]++;
          ten_cnt[i] = 0;
        end
        if (sv[i] && sr[i]) begin
          exp_q[i].push_back(sd[i]);
          sent[i]++;
          ten_cnt[i]++;
        end
      end
      chk("sel_exclusive", sel[0] & sel[1], 1'b0);
      chk("own_exclusive", own[0] & own[1], 1'b0);
      grant_prev = grant;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int k;
  int g0;
  int rx_target;

  initial begin
    rst   = 1'b1;
    inj_b = 1'b0;
    tick(3);
    chk("rst_ctrl_a", {req[0], grant[0], sel[0], lv[0], own[0], perr[0], sr[0]}, 0);
    chk("rst_ctrl_b", {req[1], grant[1], sel[1], lv[1], own[1], perr[1], sr[1]}, 0);
    chk("rst_data", {ld[0], ld[1]}, 0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_own", own, 2'b01);

    // A streams three flits while B is idle.
    base[0]  = 32'hA0;
    quota[0] = 3;
    for (k = 0; k < 40 && rx_cnt[0] < 3; k++) tick(1);
    chk("burst_a_count", rx_cnt[0], 3);
    chk("burst_a_f0", rx_log[0], 32'hA0);
    chk("burst_a_f1", rx_log[1], 32'hA1);
    chk("burst_a_f2", rx_log[2], 32'hA2);
    chk("burst_a_sel_seen", sel_a_seen, 1'b1);
    chk("burst_no_grant", gcnt, 0);
    tick(5);

    // B wants the channel while A idles: req, TURN, grant, then B owns.
    base[1]   = 32'hB000_0000;
    quota[1]  = sent[1] + 4;
    rx_target = rx_cnt[1] + 4;
    tick(1);
    chk("ho_req_lag", req[1], 1'b0);
    tick(1);
    chk("ho_req", req[1], 1'b1);
    tick(1);
    chk("ho_turn_own_sel", {own[0], sel[0]}, 2'b10);
    tick(1);
    chk("ho_grant", {grant[0], own[0], own[1]}, 3'b100);
    tick(1);
    chk("ho_b_own", own, 2'b10);
    for (k = 0; k < 40 && rx_cnt[1] < rx_target; k++) tick(1);
    chk("ho_b_flits", rx_cnt[1], rx_target);
    tick(3);

    // Stray grant into the current owner is flagged and otherwise ignored.
    inj_b = 1'b1;
    tick(1);
    inj_b = 1'b0;
    chk("perr_set", perr, 2'b10);
    chk("perr_own_kept", own, 2'b10);
    tick(2);
    chk("perr_state_kept", {own, grant, perr}, 6'b10_00_10);

    // Both saturated: every complete tenure carries exactly MAX_HOLD flits.
    ten_idx[0] = 0;
    ten_idx[1] = 0;
    sat_mode   = 1'b1;
    pct[0]     = 100;
    pct[1]     = 100;
    quota[0]   = sent[0] + 1000000;
    quota[1]   = sent[1] + 1000000;
    tick(250);
    chk("sat_tenures", (ten_idx[0] + ten_idx[1]) >= 10, 1'b1);

    // Reset while A is mid-burst.
    for (k = 0; k < 60 && !(sr[0] && sv[0]); k++) tick(1);
    chk("found_a_tx", sr[0] & sv[0], 1'b1);
    rst      = 1'b1;
    sat_mode = 1'b0;
    tick(1);
    chk("midrst_a", {req[0], grant[0], sel[0], lv[0], own[0], perr[0], sr[0]}, 0);
    chk("midrst_b", {req[1], grant[1], sel[1], lv[1], own[1], perr[1], sr[1]}, 0);
    quota[0] = sent[0];
    quota[1] = sent[1];
    rst = 1'b0;
    tick(1);
    chk("midrst_own", own, 2'b01);

    // Randomized traffic from both ends.
    g0 = gcnt;
    for (int r = 0; r < 15; r++) begin
      pct[0]   = $urandom_range(90, 10);
      pct[1]   = $urandom_range(90, 10);
      quota[0] = sent[0] + $urandom_range(60, 5);
      quota[1] = sent[1] + $urandom_range(60, 5);
      tick(200);
    end
    quota[0] = sent[0];
    quota[1] = sent[1];
    tick(30);
    chk("rand_handovers", (gcnt - g0) > 10, 1'b1);
    chk("rand_drained", exp_q[0].size() + exp_q[1].size(), 0);
    chk("rand_no_perr", perr, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
